scarv_cop_insn_fifo: RTL
========================

Name: scarv_cop_insn_fifo

Overview:
- Instruction issue buffer between the host CPU's coprocessor request port and the combinational ISE instruction decoder.
- Accepts 32-bit encodings plus the GPR rs1 operand value via a req/ack handshake.
- Holds them in a small in-order FIFO and presents the head entry to the decoder and execute stage with a valid/ready handshake.
- Supports a synchronous flush for pipeline kills and tags each issued instruction with a wrapping sequence number.

Parameters:
- DEPTH, 2, number of FIFO entries; must be a power of two, 2..8.
- TAG_W, 3, width of the issue sequence tag.

Ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_resetn  in  1  asynchronous active-low reset.
- cpu_insn_req  in  1  CPU offers an instruction this cycle.
- cpu_insn_ack  out  1  buffer accepts the offered instruction this cycle.
- cpu_insn_enc  in  32  encoded instruction word.
- cpu_rs1  in  32  value of GPR rs1 sampled by the CPU.
- flush  in  1  discard all buffered instructions.
- id_valid  out  1  head entry valid.
- id_ready  in  1  execute stage consumes head this cycle.
- id_encoded  out  32  head encoding, to decoder id_encoded.
- id_rs1_val  out  32  head rs1 operand value.
- id_tag  out  TAG_W  sequence tag of head entry.
- fifo_count  out  4  current occupancy, 0..DEPTH.

Behaviour:
- Reset (g_resetn low, asynchronous): read/write pointers = 0, count = 0, tag counter = 0.
- Reset values of outputs: cpu_insn_ack = 0, id_valid = 0, id_encoded = 0, id_rs1_val = 0, id_tag = 0, fifo_count = 0.
- Storage array contents need not be reset; outputs are gated to 0 when empty.
- Ack rule: cpu_insn_ack = cpu_insn_req & ~full & ~flush, combinational.
  - full is defined as count == DEPTH, using registered state only.
  - There is no pass-through: when full, ack = 0 even if a pop occurs in the same cycle.
- Push: occurs when cpu_insn_req & cpu_insn_ack.
  - {cpu_insn_enc, cpu_rs1} is written at the write pointer.
  - The write pointer increments modulo DEPTH.
- Pop: occurs when id_valid & id_ready.
  - The read pointer increments modulo DEPTH.
  - The tag counter increments modulo 2^TAG_W.
- id_ready while id_valid = 0 is ignored: no pointer, count or tag change.
- Head outputs:
  - id_valid = (count != 0).
  - id_encoded / id_rs1_val = entry at the read pointer when id_valid, else 0.
  - id_tag = tag counter.
  - Data is visible in the cycle after the push edge: one-cycle latency from push to id_valid.
- Count:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - push & pop: unchanged.
  - fifo_count reflects the registered count.
- Count invariants: count never exceeds DEPTH and never underflows. The bench asserts both.
- Flush (synchronous, highest priority):
  - On a cycle with flush = 1, the next state is pointers = 0 and count = 0.
  - Any concurrent pop is discarded.
  - The tag counter is NOT reset, so tags of killed instructions are never reused before wrap.
  - No push occurs in that cycle, because ack is forced low.
  - id_valid may still be 1 during the flush cycle; downstream must qualify with flush.
- Ordering: strict FIFO; entries leave in acceptance order.
- Reset mid-operation: all occupancy is lost immediately, with no handshake completion. The CPU must re-issue.
- Wrap-around: pointers wrap at DEPTH with no bubble. Back-to-back push/pop at full throughput sustains 1 instruction per cycle when count is between 1 and DEPTH-1.

Test Plan:
1. Reset, then push enc=0x0000_702B, rs1=0x1234_5678 with id_ready=0 -> ack=1 on that cycle; the next cycle gives id_valid=1, id_encoded=0x0000_702B, id_rs1_val=0x1234_5678, id_tag=0, fifo_count=1.
2. DEPTH=2: push A, B with id_ready=0, then hold req with C -> ack=0 while count=2; assert id_ready for one cycle -> A pops and C is accepted only on the following cycle; order of head values is A, B, C with tags 0, 1, 2.
3. Continuous req and id_ready=1 for 20 instructions after one priming push -> one push and one pop per cycle; count stays 1; tag wraps 7->0 at the 9th pop; no entry lost or duplicated.
4. Fill to 2 entries, assert flush together with req and id_ready -> ack=0 that cycle; the next cycle gives count=0, id_valid=0, id_encoded=0; the tag is unchanged from its pre-flush value (not incremented by the killed pop).
5. With 2 entries held, drop g_resetn asynchronously mid-cycle -> all outputs go to 0 immediately without a clock edge; after release, the first push gets tag 0.
6. id_ready=1 while empty for 5 cycles -> count, pointers and tag all unchanged; the underflow assertion never fires.

Source files
------------

// File: rtl/scarv_cop_insn_fifo.sv
// rtl/scarv_cop_insn_fifo.sv - in-order issue buffer between CPU coprocessor port and ISE decoder
module scarv_cop_insn_fifo #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 3
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic              cpu_insn_req,
    output logic              cpu_insn_ack,
    input  logic [31:0]       cpu_insn_enc,
    input  logic [31:0]       cpu_rs1,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_encoded,
    output logic [31:0]       id_rs1_val,
    output logic [TAG_W-1:0]  id_tag,
    output logic [3:0]        fifo_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [3:0]       count;
    logic [TAG_W-1:0] tag_ctr;

    logic full;
    logic push;
    logic pop;
    logic [63:0] head;

    assign full = (count == DEPTH_C);

    // No pass-through: a same-cycle pop never frees a slot for the offered word.
    // Held low in reset so nothing looks accepted while state is being cleared.
    assign cpu_insn_ack = cpu_insn_req & ~full & ~flush & g_resetn;
    assign push         = cpu_insn_req & cpu_insn_ack;

    assign id_valid = (count != 4'd0);
    // A pop coinciding with flush is killed and must not advance the tag.
    assign pop      = id_valid & id_ready & ~flush;

    assign head       = mem[rd_ptr];
    assign id_encoded = id_valid ? head[63:32] : 32'd0;
    assign id_rs1_val = id_valid ? head[31:0]  : 32'd0;
    assign id_tag     = tag_ctr;
    assign fifo_count = count;

    always_ff @(posedge g_clk) begin
        if (push) begin
            mem[wr_ptr] <= {cpu_insn_enc, cpu_rs1};
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Tags survive flush so killed instructions' tags are not reissued before wrap.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            tag_ctr <= '0;
        end else if (pop) begin
            tag_ctr <= tag_ctr + TAG_W'(1);
        end
    end

endmodule
